spi_cmd_master: RTL and testbench
=================================

Name: spi_cmd_master

Overview:
Upstream stage of the serial memory-access slave. It takes one parallel command (address, write flag, write data) over a valid/ready handshake. It serializes the command as a single chip-select framed SPI mode-0 transfer and captures read data from miso. The result is returned as a one-cycle response pulse. It sits between the on-chip controller and the off-block serial slave/BRAM.

Parameters:
ADDR_W, 5, address bits per frame (sent first, MSB first)
DATA_W, 16, data bits per frame (sent/received last, MSB first)
CLK_DIV, 4, sclk half-period in clk cycles (legal range >= 1)
CS_GAP, 2, minimum clk cycles cs_n stays high between frames (legal range >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  command present
req_ready  output  1  block can accept a command (high only in IDLE)
req_addr  input  ADDR_W  target address
req_we  input  1  1 = write, 0 = read
req_wdata  input  DATA_W  write data (ignored on reads)
rsp_valid  output  1  one-cycle pulse: frame finished
rsp_rdata  output  DATA_W  captured read data; 0 for writes; held until the next rsp_valid
busy  output  1  high from accept until return to IDLE
sclk  output  1  serial clock, idles low
cs_n  output  1  chip select, active low, idles high
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, sclk=0, cs_n=1, mosi=0. Reset mid-frame aborts it: cs_n high, no rsp_valid.
- Frame: FRAME_BITS = ADDR_W+1+DATA_W (22) bits. Order is addr[ADDR_W-1:0] MSB first, then we, then the data field.
  - Write: data field on mosi is wdata MSB first.
  - Read: mosi=0 during the data field; miso is sampled.
- Accept: req_valid && req_ready at edge N. Command is latched into the shift register. req_ready and busy update at the same edge.
- State SHIFT, from edge N: cs_n=0, sclk=0, mosi=frame bit 0.
  - Each bit has a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
  - mosi changes only at the edge where sclk falls, or at frame start.
  - On the edge where sclk rises, miso is shifted into the capture register, during data-field bits of read frames only.
- State TAIL: after the high phase of bit FRAME_BITS-1, sclk=0 and cs_n stays 0 for CLK_DIV cycles.
  - cs_n low duration = (2*FRAME_BITS+1)*CLK_DIV cycles (90 at CLK_DIV=2).
- State GAP: cs_n=1, mosi=0. rsp_valid=1 for exactly the first GAP cycle, with rsp_rdata updated in that same cycle. Stay CS_GAP cycles, then go to IDLE with req_ready=1.
- Transitions: IDLE->SHIFT on accept. SHIFT->TAIL after the last high phase. TAIL->GAP. GAP->IDLE.
- req_valid outside IDLE is ignored (no queueing). Command inputs are only sampled at accept.
- The sclk divider is a counter 0..CLK_DIV-1 that wraps. Bit counter width is clog2(FRAME_BITS+1).
- CLK_DIV=1: sclk toggles every cycle. Behaviour is otherwise identical.

Decomposition:
- Package spi_cmd_pkg:
  - ADDR_W/DATA_W defaults
  - FRAME_BITS function
  - state enum {IDLE, SHIFT, TAIL, GAP}
- Sub-module spi_sclk_gen: half-period counter emitting rise/fall strobes and sclk. It is enabled by the FSM and clears on disable.

Test Plan:
- Write, CLK_DIV=2, addr=5'h13, we=1, wdata=16'hA5C3 -> mosi sampled at 22 sclk rises = 1,0,0,1,1,1,1010010111000011. cs_n low exactly 90 cycles. rsp_valid one pulse, rsp_rdata=0.
- Read, addr=5'h04: slave model drives miso=16'h3C5A MSB first on falling edges. Expect mosi=0,0,1,0,0,0 then 16 zeros, and rsp_rdata=16'h3C5A with a single rsp_valid.
- Back-to-back: req_valid held high with two commands. Second accept occurs exactly CS_GAP+1 cycles after cs_n rises. cs_n high >= CS_GAP cycles between frames. Both responses arrive in order.
- Handshake: req_valid pulsed during SHIFT with different addr -> ignored, frame bits unchanged, req_ready=0 throughout busy.
- Reset mid-frame: assert rst_n=0 at bit 10 -> cs_n=1, sclk=0, mosi=0 immediately, no rsp_valid. After release, a new write completes normally.
- CLK_DIV=1 sweep: write 16'hFFFF to addr 5'h1F -> 22 ones on mosi, cs_n low 45 cycles, sclk period 2 cycles.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and sizing helpers for the SPI command master.
package spi_cmd_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;

    function automatic int frame_bits(input int aw, input int dw);
        return aw + 1 + dw;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        TAIL,
        GAP
    } state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider for the SPI serial clock; strobes mark the clk edge
// at which sclk is about to rise or fall. Clears to idle-low when disabled.
module spi_sclk_gen
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          wrap;

    always_comb begin
        wrap   = en && (cnt_q == LAST);
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            sclk_d = !sclk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;
    assign rise = wrap && !sclk_q;
    assign fall = wrap && sclk_q;

endmodule

// File: rtl/spi_cmd_master.sv
// Serializes one {addr, we, data} command per chip-select frame (SPI mode 0)
// and returns the captured read data as a single-cycle response.
module spi_cmd_master
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int FB   = frame_bits(ADDR_W, DATA_W);
    localparam int BCW  = $clog2(FB + 1);
    localparam int TMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [BCW-1:0] LAST_BIT   = BCW'(FB - 1);
    localparam logic [BCW-1:0] DATA_START = BCW'(ADDR_W + 1);
    localparam logic [TW-1:0]  TAIL_LAST  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0]  GAP_LAST   = TW'(CS_GAP - 1);

    state_e            state_q, state_d;
    logic [FB-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              we_q, we_d;
    logic              cs_n_q, cs_n_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic              accept;
    logic              sclk_en, sclk_rise, sclk_fall;
    logic [DATA_W-1:0] wfield;

    assign req_ready = (state_q == IDLE);
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    assign sclk_en   = (state_q == SHIFT);
    assign wfield    = req_we ? req_wdata : '0;

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sclk_en),
        .sclk (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cap_d       = cap_q;
        rdata_d     = rdata_q;
        bit_d       = bit_q;
        tmr_d       = tmr_q;
        we_d        = we_q;
        cs_n_d      = cs_n_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shreg_d = {req_addr, req_we, wfield};
                    we_d    = req_we;
                    cap_d   = '0;
                    bit_d   = '0;
                    cs_n_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (sclk_rise && !we_q && (bit_q >= DATA_START)) begin
                    cap_d = {cap_q[DATA_W-2:0], miso};
                end
                // Shifting in zeros leaves mosi low once the last bit is out.
                if (sclk_fall) begin
                    shreg_d = {shreg_q[FB-2:0], 1'b0};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = TAIL;
                        tmr_d   = '0;
                    end
                end
            end
            TAIL: begin
                if (tmr_q == TAIL_LAST) begin
                    state_d     = GAP;
                    tmr_d       = '0;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? '0 : cap_q;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            GAP: begin
                if (tmr_q == GAP_LAST) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cap_q       <= '0;
            rdata_q     <= '0;
            bit_q       <= '0;
            tmr_q       <= '0;
            we_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cap_q       <= cap_d;
            rdata_q     <= rdata_d;
            bit_q       <= bit_d;
            tmr_q       <= tmr_d;
            we_q        <= we_d;
            cs_n_q      <= cs_n_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign cs_n      = cs_n_q;
    assign mosi      = shreg_q[FB-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two instances (CLK_DIV=2 and CLK_DIV=1), a bus
// monitor with a mode-0 slave model, and frame-level expectations.
module tb_spi_cmd_master;

    localparam int AW    = 5;
    localparam int DW    = 16;
    localparam int FB    = AW + 1 + DW;
    localparam int DIV0  = 2;
    localparam int DIV1  = 1;
    localparam int GAP_C = 2;

    typedef struct {
        int          inst;
        logic [31:0] bits;
        int          nbits;
        int          cslen;
        int          rmin;
        int          rmax;
    } frame_t;

    typedef struct {
        int          inst;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] req_valid, req_ready, req_we, rsp_valid, busy, sclk, cs_n, mosi, miso;
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] req_wdata [2];
    logic [DW-1:0] rsp_rdata [2];
    logic [DW-1:0] slave_data [2];

    int checks = 0;
    int errors = 0;
    int ncyc = 0;
    frame_t frame_q[$];
    rsp_t   rsp_q[$];
    int     acc_at[$];
    int     cs_rise_at[$];

    always #5 clk = ~clk;

    spi_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DIV0), .CS_GAP(GAP_C)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_we(req_we[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
    );

    spi_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .CLK_DIV(DIV1), .CS_GAP(GAP_C)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_we(req_we[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
    );

    // Reference: frame content and response follow directly from the command.
    function automatic logic [FB-1:0] model_frame(input logic [AW-1:0] a, input logic w,
                                                  input logic [DW-1:0] d);
        logic [DW-1:0] f;
        f = w ? d : '0;
        return {a, w, f};
    endfunction

    function automatic logic [DW-1:0] model_rdata(input logic w, input logic [DW-1:0] sd);
        return w ? '0 : sd;
    endfunction

    // Bus monitor + slave: sampled on the falling clk edge, away from the DUT edge.
    initial begin
        frame_t cur [2];
        int     nfalls [2];
        int     last_rise [2];
        logic   p_sclk [2];
        logic   p_cs [2];
        int     d;
        int     idx;
        rsp_t   r;
        miso = '0;
        for (int i = 0; i < 2; i++) begin
            p_sclk[i] = 1'b0; p_cs[i] = 1'b1; nfalls[i] = 0; last_rise[i] = -1;
            cur[i].inst = i; cur[i].bits = '0; cur[i].nbits = 0; cur[i].cslen = 0;
            cur[i].rmin = 1000; cur[i].rmax = 0;
        end
        forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 2; i++) begin
                if (p_cs[i] && !cs_n[i]) begin
                    cur[i].inst = i; cur[i].bits = '0; cur[i].nbits = 0; cur[i].cslen = 0;
                    cur[i].rmin = 1000; cur[i].rmax = 0;
                    nfalls[i] = 0; last_rise[i] = -1; miso[i] = 1'b0;
                end
                if (!cs_n[i]) begin
                    cur[i].cslen++;
                    if (sclk[i] && !p_sclk[i]) begin
                        cur[i].bits = {cur[i].bits[30:0], mosi[i]};
                        cur[i].nbits++;
                        if (last_rise[i] >= 0) begin
                            d = ncyc - last_rise[i];
                            if (d < cur[i].rmin) cur[i].rmin = d;
                            if (d > cur[i].rmax) cur[i].rmax = d;
                        end
                        last_rise[i] = ncyc;
                    end
                    if (!sclk[i] && p_sclk[i]) begin
                        nfalls[i]++;
                        idx = DW - 1 - (nfalls[i] - (AW + 1));
                        miso[i] = (nfalls[i] >= AW + 1 && nfalls[i] < FB) ? slave_data[i][idx] : 1'b0;
                    end
                end
                if (!p_cs[i] && cs_n[i]) begin
                    frame_q.push_back(cur[i]);
                    cs_rise_at.push_back(ncyc);
                    miso[i] = 1'b0;
                end
                if (rsp_valid[i]) begin
                    r.inst = i; r.data = rsp_rdata[i];
                    rsp_q.push_back(r);
                end
                if (req_valid[i] && req_ready[i]) acc_at.push_back(ncyc);
                p_sclk[i] = sclk[i];
                p_cs[i]   = cs_n[i];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_q;
        frame_q.delete(); rsp_q.delete(); acc_at.delete(); cs_rise_at.delete();
    endtask

    task automatic wait_idle(input int i);
        int k = 0;
        while (busy[i] && k < 500) begin @(posedge clk); #1; k++; end
        checks++;
        if (busy[i]) begin
            errors++;
            $display("FAIL idle_timeout inst%0d: busy=%b, required 0", i, busy[i]);
        end
    endtask

    task automatic send(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        int k = 0;
        wait_idle(i);
        req_addr[i] = a; req_we[i] = w; req_wdata[i] = d; req_valid[i] = 1'b1;
        do begin @(posedge clk); #1; k++; end while (!busy[i] && k < 20);
        req_valid[i] = 1'b0;
        checks++;
        if (!busy[i]) begin
            errors++;
            $display("FAIL accept inst%0d: busy=%b after %0d cycles, required 1", i, busy[i], k);
        end
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        rsp_t   rd;
        frame_t fd;
        while (rsp_q.size() < n && k < 3000) begin @(posedge clk); #1; k++; end
        checks++;
        if (rsp_q.size() < n) begin
            errors++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_q.size(), n);
            rd.inst = -1; rd.data = 'x;
            fd.inst = -1; fd.bits = 'x; fd.nbits = -1; fd.cslen = -1; fd.rmin = -1; fd.rmax = -1;
            while (rsp_q.size() < n) rsp_q.push_back(rd);
            while (frame_q.size() < n) frame_q.push_back(fd);
        end
    endtask

    task automatic do_frame(input int i, input logic [AW-1:0] a, input logic w,
                            input logic [DW-1:0] d, input logic [DW-1:0] sd);
        slave_data[i] = sd;
        clear_q();
        send(i, a, w, d);
        wait_rsp(1);
        wait_idle(i);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready[0], busy[0], rsp_valid[0], sclk[0], cs_n[0], mosi[0]} !== 6'b100010) begin
            errors++;
            $display("FAIL reset_ctrl0: got %b, required 100010",
                     {req_ready[0], busy[0], rsp_valid[0], sclk[0], cs_n[0], mosi[0]});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_rdata[0] !== '0) begin
            errors++; $display("FAIL reset_rdata0: got %h, required 0000", rsp_rdata[0]);
        end
        checks++;
        if ({req_ready[1], busy[1], rsp_valid[1], sclk[1], cs_n[1], mosi[1], rsp_rdata[1]} !== {6'b100010, 16'h0}) begin
            errors++;
            $display("FAIL reset_dut1: got %b/%h, required 100010/0000",
                     {req_ready[1], busy[1], rsp_valid[1], sclk[1], cs_n[1], mosi[1]}, rsp_rdata[1]);
        end
    endtask

    task automatic test_write;
        logic [FB-1:0] exp_f;
        exp_f = model_frame(5'h13, 1'b1, 16'hA5C3);
        do_frame(0, 5'h13, 1'b1, 16'hA5C3, 16'hFFFF);
        checks++;
        if (frame_q[0].bits[FB-1:0] !== exp_f || frame_q[0].nbits != FB) begin
            errors++;
            $display("FAIL write_bits: got %b (%0d bits), required %b (%0d bits)",
                     frame_q[0].bits[FB-1:0], frame_q[0].nbits, exp_f, FB);
        end
        checks++;
        if (frame_q[0].cslen != (2 * FB + 1) * DIV0) begin
            errors++; $display("FAIL write_cslen: got %0d, required %0d", frame_q[0].cslen, (2 * FB + 1) * DIV0);
        end
        checks++;
        if (frame_q[0].rmin != 2 * DIV0 || frame_q[0].rmax != 2 * DIV0) begin
            errors++;
            $display("FAIL write_sclk_period: got %0d..%0d, required %0d", frame_q[0].rmin, frame_q[0].rmax, 2 * DIV0);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].data !== 16'h0) begin
            errors++;
            $display("FAIL write_rsp: got %0d pulses data %h, required 1 pulse data 0000", rsp_q.size(), rsp_q[0].data);
        end
    endtask

    task automatic test_read;
        logic [FB-1:0] exp_f;
        exp_f = model_frame(5'h04, 1'b0, 16'hBEEF);
        do_frame(0, 5'h04, 1'b0, 16'hBEEF, 16'h3C5A);
        checks++;
        if (frame_q[0].bits[FB-1:0] !== exp_f) begin
            errors++; $display("FAIL read_bits: got %b, required %b", frame_q[0].bits[FB-1:0], exp_f);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].data !== 16'h3C5A) begin
            errors++;
            $display("FAIL read_rsp: got %0d pulses data %h, required 1 pulse data 3c5a", rsp_q.size(), rsp_q[0].data);
        end
    endtask

    task automatic test_random;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d, sd;
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom); w = 1'($urandom_range(0, 1)); d = DW'($urandom); sd = DW'($urandom);
            do_frame(0, a, w, d, sd);
            checks++;
            if (frame_q[0].bits[FB-1:0] !== model_frame(a, w, d) || frame_q[0].nbits != FB) begin
                errors++;
                $display("FAIL rand%0d_bits: got %b, required %b", n, frame_q[0].bits[FB-1:0], model_frame(a, w, d));
            end
            checks++;
            if (frame_q[0].cslen != (2 * FB + 1) * DIV0) begin
                errors++; $display("FAIL rand%0d_cslen: got %0d, required %0d", n, frame_q[0].cslen, (2 * FB + 1) * DIV0);
            end
            checks++;
            if (rsp_q.size() != 1 || rsp_q[0].data !== model_rdata(w, sd)) begin
                errors++;
                $display("FAIL rand%0d_rsp: got %0d pulses data %h, required 1 pulse data %h",
                         n, rsp_q.size(), rsp_q[0].data, model_rdata(w, sd));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic          w [2];
        logic [DW-1:0] sd;
        int k;
        for (int j = 0; j < 2; j++) begin
            a[j] = AW'($urandom); d[j] = DW'($urandom); w[j] = (j == 0);
        end
        sd = DW'($urandom);
        slave_data[0] = sd;
        wait_idle(0);
        clear_q();
        req_addr[0] = a[0]; req_we[0] = w[0]; req_wdata[0] = d[0]; req_valid[0] = 1'b1;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!busy[0] && k < 20);
        req_addr[0] = a[1]; req_we[0] = w[1]; req_wdata[0] = d[1];
        k = 0;
        while (busy[0] && k < 300) begin @(posedge clk); #1; k++; end
        k = 0;
        while (!busy[0] && k < 20) begin @(posedge clk); #1; k++; end
        req_valid[0] = 1'b0;
        wait_rsp(2);
        wait_idle(0);
        checks++;
        if (acc_at.size() != 2 || cs_rise_at.size() < 1) begin
            errors++; $display("FAIL b2b_accepts: got %0d accepts, required 2", acc_at.size());
        end else begin
            checks++;
            if (acc_at[1] - cs_rise_at[0] != GAP_C) begin
                errors++;
                $display("FAIL b2b_gap: second accept %0d cycles after cs_n rise, required %0d",
                         acc_at[1] - cs_rise_at[0] + 1, GAP_C + 1);
            end
        end
        checks++;
        if (rsp_q[0].data !== model_rdata(w[0], sd) || rsp_q[1].data !== model_rdata(w[1], sd)) begin
            errors++;
            $display("FAIL b2b_rsp_order: got %h,%h, required %h,%h",
                     rsp_q[0].data, rsp_q[1].data, model_rdata(w[0], sd), model_rdata(w[1], sd));
        end
        checks++;
        if (frame_q[0].bits[FB-1:0] !== model_frame(a[0], w[0], d[0]) ||
            frame_q[1].bits[FB-1:0] !== model_frame(a[1], w[1], d[1])) begin
            errors++;
            $display("FAIL b2b_bits: got %b,%b, required %b,%b", frame_q[0].bits[FB-1:0], frame_q[1].bits[FB-1:0],
                     model_frame(a[0], w[0], d[0]), model_frame(a[1], w[1], d[1]));
        end
    endtask

    task automatic test_handshake;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int bad, k;
        a = 5'h0A; d = DW'($urandom);
        clear_q();
        send(0, a, 1'b1, d);
        bad = 0; k = 0;
        while (busy[0] && k < 300) begin
            if (req_ready[0]) bad++;
            if (k >= 10 && k < 14) begin
                req_valid[0] = 1'b1; req_addr[0] = ~a; req_we[0] = 1'b0; req_wdata[0] = ~d;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(posedge clk); #1; k++;
        end
        req_valid[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hs_ready_busy: req_ready high on %0d busy cycles, required 0", bad);
        end
        checks++;
        if (acc_at.size() != 1 || frame_q.size() != 1 || rsp_q.size() != 1) begin
            errors++;
            $display("FAIL hs_count: got %0d accepts %0d frames %0d rsps, required 1 each",
                     acc_at.size(), frame_q.size(), rsp_q.size());
        end
        checks++;
        if (frame_q[0].bits[FB-1:0] !== model_frame(a, 1'b1, d)) begin
            errors++; $display("FAIL hs_bits: got %b, required %b", frame_q[0].bits[FB-1:0], model_frame(a, 1'b1, d));
        end
    endtask

    task automatic test_reset_mid;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        clear_q();
        send(0, 5'h15, 1'b1, 16'h1234);
        repeat (20 * DIV0 + 1) @(posedge clk);
        #2;
        checks++;
        if (cs_n[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_inframe: cs_n=%b before reset, required 0", cs_n[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cs_n[0], sclk[0], mosi[0], busy[0], req_ready[0]} !== 5'b10001) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b, required 10001", {cs_n[0], sclk[0], mosi[0], busy[0], req_ready[0]});
        end
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (rsp_q.size() != 0) begin
            errors++; $display("FAIL rstmid_no_rsp: got %0d responses, required 0", rsp_q.size());
        end
        a = AW'($urandom); d = DW'($urandom);
        do_frame(0, a, 1'b1, d, 16'h0);
        checks++;
        if (frame_q[0].bits[FB-1:0] !== model_frame(a, 1'b1, d) || frame_q[0].cslen != (2 * FB + 1) * DIV0) begin
            errors++;
            $display("FAIL rstmid_after: got %b len %0d, required %b len %0d", frame_q[0].bits[FB-1:0],
                     frame_q[0].cslen, model_frame(a, 1'b1, d), (2 * FB + 1) * DIV0);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].data !== 16'h0) begin
            errors++; $display("FAIL rstmid_rsp: got %0d pulses data %h, required 1 pulse 0000", rsp_q.size(), rsp_q[0].data);
        end
    endtask

    task automatic test_clkdiv1;
        logic [AW-1:0] a;
        logic [DW-1:0] sd;
        do_frame(1, 5'h1F, 1'b1, 16'hFFFF, 16'h0);
        checks++;
        if (frame_q[0].bits[FB-1:0] !== {FB{1'b1}} || frame_q[0].nbits != FB) begin
            errors++; $display("FAIL div1_bits: got %b (%0d), required all ones (%0d)",
                               frame_q[0].bits[FB-1:0], frame_q[0].nbits, FB);
        end
        checks++;
        if (frame_q[0].cslen != (2 * FB + 1) * DIV1) begin
            errors++; $display("FAIL div1_cslen: got %0d, required %0d", frame_q[0].cslen, (2 * FB + 1) * DIV1);
        end
        checks++;
        if (frame_q[0].rmin != 2 || frame_q[0].rmax != 2) begin
            errors++; $display("FAIL div1_period: got %0d..%0d, required 2", frame_q[0].rmin, frame_q[0].rmax);
        end
        checks++;
        if (rsp_q.size() != 1 || rsp_q[0].data !== 16'h0 || rsp_q[0].inst != 1) begin
            errors++; $display("FAIL div1_wrsp: got %0d pulses data %h, required 1 pulse 0000", rsp_q.size(), rsp_q[0].data);
        end
        a = AW'($urandom); sd = DW'($urandom);
        do_frame(1, a, 1'b0, 16'h0, sd);
        checks++;
        if (frame_q[0].bits[FB-1:0] !== model_frame(a, 1'b0, 16'h0) || rsp_q[0].data !== sd) begin
            errors++;
            $display("FAIL div1_read: got %b data %h, required %b data %h",
                     frame_q[0].bits[FB-1:0], rsp_q[0].data, model_frame(a, 1'b0, 16'h0), sd);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_we = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = '0; req_wdata[i] = '0; slave_data[i] = '0;
        end
        test_reset();
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_handshake();
        test_reset_mid();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
